// File: rtl/alu_pkg.sv
// Shared constants for the ALU result stage: mode encodings, flag bit
// positions and the default datapath width.
package alu_pkg;

    localparam logic [2:0] MODE_ADD  = 3'd0;
    localparam logic [2:0] MODE_AND  = 3'd1;
    localparam logic [2:0] MODE_OR   = 3'd2;
    localparam logic [2:0] MODE_XOR  = 3'd3;
    localparam logic [2:0] MODE_XNOR = 3'd4;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_E = 3;

    localparam int W_DEFAULT = 8;

endpackage

// File: rtl/alu_result_fifo.sv
// Generic synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate count register.
module alu_result_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Full means the wrap bits differ while the index bits match.
    assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign empty   = (wr_ptr == rd_ptr);
    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the ALU: derives {err,neg,zero,carry} at
// push time, queues {mode,flags,data} in a small FIFO and keeps the last
// accepted result as the accumulator fed back to the ALU A operand.
// Optional statistics (carry_cnt, err_seen) are built when
// ALU_RESULT_STAT_EN is defined.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   Mode,
    input  logic [W-1:0] X,
    input  logic         C_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [3:0]   out_flags,
    output logic [2:0]   out_mode,
`ifdef ALU_RESULT_STAT_EN
    output logic [15:0]  carry_cnt,
    output logic [0:0]   err_seen,
`endif
    output logic [W-1:0] acc
);

    localparam int DW = W + 4 + 3;

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [3:0]    flags;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    // Flag derivation; illegal modes are never ADD, so their carry is 0.
    always_comb begin
        flags        = '0;
        flags[FLG_C] = (Mode == MODE_ADD) && C_out;
        flags[FLG_Z] = (X == '0);
        flags[FLG_N] = X[W-1];
        flags[FLG_E] = (Mode > MODE_XNOR);
    end

    assign in_ready  = !full || out_ready;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wdata     = {Mode, flags, X};

    // Head fields read as zero whenever nothing is queued.
    assign out_data  = empty ? '0 : rdata[W-1:0];
    assign out_flags = empty ? '0 : rdata[W+3:W];
    assign out_mode  = empty ? '0 : rdata[W+6:W+4];

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    // Accumulator tracks every accepted result, error entries included.
    always_ff @(posedge clk) begin
        if (!rst_n)    acc <= '0;
        else if (push) acc <= X;
    end

`ifdef ALU_RESULT_STAT_EN
    // Saturating carry counter and sticky error marker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_cnt <= '0;
            err_seen  <= '0;
        end else if (push) begin
            if (flags[FLG_C] && carry_cnt != 16'hFFFF) carry_cnt <= carry_cnt + 16'd1;
            if (flags[FLG_E]) err_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] Mode;
    logic [7:0] X;
    logic       C_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_flags;
    logic [2:0] out_mode;
    logic [7:0] acc;
`ifdef ALU_RESULT_STAT_EN
    logic [15:0] carry_cnt;
    logic [0:0]  err_seen;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.DEPTH(2), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Mode      (Mode),
        .X         (X),
        .C_out     (C_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .out_mode  (out_mode),
`ifdef ALU_RESULT_STAT_EN
        .carry_cnt (carry_cnt),
        .err_seen  (err_seen),
`endif
        .acc       (acc)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] m, input logic [7:0] x, input logic c);
        in_valid = v;
        Mode     = m;
        X        = x;
        C_out    = c;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_acc",       acc, 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_out_mode",  out_mode, 0);
        rst_n = 1'b1;
        tick();

        // 1: add of zero with carry -> zero+carry
        drive(1'b1, 3'd0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        chk("t1_valid", out_valid, 1);
        chk("t1_data",  out_data, 8'h00);
        chk("t1_flags", out_flags, 4'b0011);
        chk("t1_acc",   acc, 8'h00);

        // 2: AND with carry in -> carry masked, negative
        drive(1'b1, 3'd1, 8'h80, 1'b1);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        chk("t2_data",  out_data, 8'h80);
        chk("t2_flags", out_flags, 4'b0100);
        chk("t2_mode",  out_mode, 3'd1);
        chk("t2_acc",   acc, 8'h80);
        tick();
        chk("t2_drained", out_valid, 0);

        // 3: backpressure fills the FIFO, third push held off
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 8'h0F, 1'b0);
        tick();
        drive(1'b1, 3'd3, 8'hF0, 1'b1);
        #1 chk("t3_ready_1", in_ready, 1);
        tick();
        drive(1'b1, 3'd4, 8'h33, 1'b0);
        #1 chk("t3_ready_full", in_ready, 0);
        tick();
        chk("t3_head_data", out_data, 8'h0F);
        chk("t3_head_mode", out_mode, 3'd2);
        chk("t3_head_flags", out_flags, 4'b0000);
        chk("t3_acc_held",  acc, 8'hF0);

        // 4: full FIFO, push and pop together
        out_ready = 1'b1;
        #1 chk("t4_ready_pass", in_ready, 1);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        chk("t4_head_b",  out_data, 8'hF0);
        chk("t4_flags_b", out_flags, 4'b0100);
        chk("t4_acc",     acc, 8'h33);
        out_ready = 1'b0;
        #1 chk("t4_still_full", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("t4_head_c",  out_data, 8'h33);
        chk("t4_mode_c",  out_mode, 3'd4);
        tick();
        chk("t4_empty",   out_valid, 0);

        // 5: illegal mode -> err only, data kept
        drive(1'b1, 3'd6, 8'h5A, 1'b1);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        chk("t5_flags", out_flags, 4'b1000);
        chk("t5_data",  out_data, 8'h5A);
        chk("t5_mode",  out_mode, 3'd6);
        chk("t5_acc",   acc, 8'h5A);
`ifdef ALU_RESULT_STAT_EN
        chk("t5_err_seen",  err_seen, 1);
        chk("t5_carry_cnt", carry_cnt, 1);
`endif
        tick();

        // 6: two entries queued, then reset with a push in flight
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 8'hFF, 1'b1);
        tick();
        chk("t6_flags_nc", out_flags, 4'b0101);
        drive(1'b1, 3'd0, 8'h01, 1'b0);
        tick();
        chk("t6_full", in_ready, 0);
        out_ready = 1'b1;
        drive(1'b1, 3'd0, 8'h77, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        out_ready = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_ready", in_ready, 1);
        chk("t6_acc",   acc, 0);
        chk("t6_data",  out_data, 0);
`ifdef ALU_RESULT_STAT_EN
        chk("t6_carry_cnt", carry_cnt, 0);
        chk("t6_err_seen",  err_seen, 0);
`endif
        tick();
        chk("t6_stays_empty", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
